// File: rtl/icache_refill_if.sv
// AXI4 read-address and read-data channels used by the instruction-cache refill engine.
interface icache_refill_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/icache_refill.sv
// Instruction-cache line refill: one 8-beat AXI INCR burst per miss, data RAM write per beat,
// critical-word forward, then a tag write and a one-cycle completion pulse.
module icache_refill #(
   parameter logic [3:0] AXI_ID = 4'd0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tag_work,
   input  logic              miss_req,
   input  logic [31:0]       miss_addr,
   output logic              miss_ready,
   icache_refill_if.master   axi,
   output logic              data_wen,
   output logic [6:0]        data_windex,
   output logic [2:0]        data_woffset,
   output logic [31:0]       data_wdata,
   output logic [3:0]        tag_wen,
   output logic [6:0]        tag_windex,
   output logic [20:0]       tag_wdata,
   output logic              crit_valid,
   output logic [31:0]       crit_data,
   output logic              refill_done,
   output logic              refill_err
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_TAG  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [31:2] addr_r;
   logic        err_r;
   logic [2:0]  beat_r;
   logic        crit_sent_r;

   logic        accept_s;
   logic        beat_s;
   logic        crit_s;
   logic        miss_ready_s;
   logic        arvalid_s;
   logic        rready_s;
   logic        tag_we_s;
   logic        done_s;
   logic        unused_s;

   function automatic logic [6:0] line_index(input logic [31:2] a);
      return a[11:5];
   endfunction

   // Next-state and per-state control decode.
   always_comb begin
      state_s      = state_r;
      accept_s     = 1'b0;
      beat_s       = 1'b0;
      crit_s       = 1'b0;
      miss_ready_s = 1'b0;
      arvalid_s    = 1'b0;
      rready_s     = 1'b0;
      tag_we_s     = 1'b0;
      done_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            miss_ready_s = tag_work & ~rst;
            if (miss_req && miss_ready_s) begin
               accept_s = 1'b1;
               state_s  = ST_AR;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_AR: begin
            arvalid_s = 1'b1;
            if (axi.arready) begin
               state_s = ST_R;
            end else begin
               state_s = ST_AR;
            end
         end
         ST_R: begin
            // No beat is taken in a reset cycle, so an abandoned burst never touches the data RAM.
            rready_s = ~rst;
            beat_s   = axi.rvalid & rready_s;
            if (beat_s && (beat_r == addr_r[4:2]) && !crit_sent_r) begin
               crit_s = 1'b1;
            end else begin
               crit_s = 1'b0;
            end
            if (beat_s && axi.rlast) begin
               state_s = ST_TAG;
            end else begin
               state_s = ST_R;
            end
         end
         ST_TAG: begin
            tag_we_s = 1'b1;
            state_s  = ST_DONE;
         end
         ST_DONE: begin
            done_s  = 1'b1;
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, latched miss address, beat counter and sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         addr_r      <= 30'd0;
         err_r       <= 1'b0;
         beat_r      <= 3'd0;
         crit_sent_r <= 1'b0;
      end else begin
         state_r <= state_s;
         if (accept_s) begin
            addr_r      <= miss_addr[31:2];
            err_r       <= 1'b0;
            beat_r      <= 3'd0;
            crit_sent_r <= 1'b0;
         end else if (beat_s) begin
            beat_r      <= beat_r + 3'd1;
            err_r       <= err_r | (axi.rresp != 2'b00);
            crit_sent_r <= crit_sent_r | crit_s;
         end else begin
            beat_r      <= beat_r;
            err_r       <= err_r;
            crit_sent_r <= crit_sent_r;
         end
      end
   end

   // Byte-lane bits of the fetch address play no part in a line refill.
   assign unused_s = ^miss_addr[1:0];

   assign miss_ready   = miss_ready_s;

   assign axi.arid     = AXI_ID;
   assign axi.araddr   = {addr_r[31:5], 5'b00000};
   assign axi.arlen    = 8'd7;
   assign axi.arsize   = 3'b010;
   assign axi.arburst  = 2'b01;
   assign axi.arvalid  = arvalid_s;
   assign axi.rready   = rready_s;

   assign data_wen     = beat_s;
   assign data_windex  = line_index(addr_r);
   assign data_woffset = beat_r;
   assign data_wdata   = axi.rdata;

   assign crit_valid   = crit_s;
   assign crit_data    = axi.rdata;

   // err_r already includes an error on the final beat, which lands on the edge into TAG.
   assign tag_wen      = tag_we_s ? 4'hF : 4'h0;
   assign tag_windex   = line_index(addr_r);
   assign tag_wdata    = {~err_r, addr_r[31:12]};

   assign refill_done  = done_s;
   assign refill_err   = done_s & err_r;

endmodule
